// File: rtl/mcu_trap_ctrl.sv
// Trap/interrupt sequencer: arbitrates exceptions, MRET and level interrupts,
// then drives the CSR trap write, the mstatus write and a one-cycle PC redirect.
module mcu_trap_ctrl #(
  parameter int unsigned WDOG_CAUSE        = 16,
  parameter logic [1:0]  RESET_MSTATUS_MPP = 2'b11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        exc_valid,
  input  logic [4:0]  exc_cause,
  input  logic [31:0] exc_pc,
  input  logic [31:0] exc_tval,
  input  logic        mret_valid,
  input  logic        irq_boundary,
  input  logic [31:0] irq_pc,
  input  logic        irq_sw,
  input  logic        irq_timer,
  input  logic        irq_ext,
  input  logic        irq_wdog,
  input  logic [31:0] csr_mstatus,
  input  logic [31:0] csr_mie,
  input  logic [31:0] csr_mtvec,
  input  logic [31:0] csr_mepc,
  output logic        trap_we,
  output logic [31:0] trap_mepc,
  output logic [31:0] trap_mcause,
  output logic [31:0] trap_mtval,
  output logic        mstatus_we,
  output logic [31:0] mstatus_wdata,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy,
  output logic [31:0] mip_value
);

  localparam int unsigned XLEN   = 32;
  localparam int unsigned CODE_W = 5;
  localparam logic [CODE_W-1:0] WDOG_CODE = CODE_W'(WDOG_CAUSE);

  typedef enum logic [1:0] {IDLE, SAVE, MSTAT, REDIR} state_t;

  state_t              state;
  state_t              state_next;
  logic                take_exc;
  logic                take_irq;
  logic                take_mret;
  logic                is_mret;
  logic [XLEN-1:0]     pending;
  logic                irq_take;
  logic [CODE_W-1:0]   irq_code;
  logic [XLEN-1:0]     mst_trap;
  logic [XLEN-1:0]     mst_mret;
  logic [XLEN-1:0]     mtvec_base;
  logic [XLEN-1:0]     redirect_target;

  // Pending view is unmasked; masking only affects whether the trap is taken.
  always_comb begin
    mip_value            = '0;
    mip_value[3]         = irq_sw;
    mip_value[7]         = irq_timer;
    mip_value[11]        = irq_ext;
    mip_value[WDOG_CODE] = irq_wdog;
  end

  assign pending  = mip_value & csr_mie;
  assign irq_take = csr_mstatus[3] & (|pending) & irq_boundary;

  always_comb begin
    if (pending[11])      irq_code = CODE_W'(11);
    else if (pending[3])  irq_code = CODE_W'(3);
    else if (pending[7])  irq_code = CODE_W'(7);
    else                  irq_code = WDOG_CODE;
  end

  always_comb begin
    mst_trap          = csr_mstatus;
    mst_trap[7]       = csr_mstatus[3];
    mst_trap[3]       = 1'b0;
    mst_trap[12:11]   = RESET_MSTATUS_MPP;
    mst_mret          = csr_mstatus;
    mst_mret[3]       = csr_mstatus[7];
    mst_mret[7]       = 1'b1;
  end

  // Vectored mode only offsets interrupts; mcause[31] marks the latched trap as one.
  always_comb begin
    mtvec_base = {csr_mtvec[31:2], 2'b00};
    if (is_mret)
      redirect_target = {csr_mepc[31:2], 2'b00};
    else if (csr_mtvec[1:0] == 2'b01 && trap_mcause[31])
      redirect_target = mtvec_base + XLEN'({trap_mcause[4:0], 2'b00});
    else
      redirect_target = mtvec_base;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    take_exc   = 1'b0;
    take_irq   = 1'b0;
    take_mret  = 1'b0;
    case (state)
      IDLE: begin
        if (exc_valid) begin
          take_exc   = 1'b1;
          state_next = SAVE;
        end else if (mret_valid) begin
          take_mret  = 1'b1;
          state_next = MSTAT;
        end else if (irq_take) begin
          take_irq   = 1'b1;
          state_next = SAVE;
        end
      end
      SAVE:    state_next = MSTAT;
      MSTAT:   state_next = REDIR;
      REDIR:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Strobes and data are loaded one edge ahead so they line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      is_mret        <= 1'b0;
      trap_we        <= 1'b0;
      trap_mepc      <= '0;
      trap_mcause    <= '0;
      trap_mtval     <= '0;
      mstatus_we     <= 1'b0;
      mstatus_wdata  <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      trap_we        <= take_exc | take_irq;
      mstatus_we     <= (state_next == MSTAT);
      redirect_valid <= (state_next == REDIR);
      if (take_exc) begin
        is_mret     <= 1'b0;
        trap_mepc   <= exc_pc;
        trap_mcause <= XLEN'(exc_cause);
        trap_mtval  <= exc_tval;
      end else if (take_irq) begin
        is_mret     <= 1'b0;
        trap_mepc   <= irq_pc;
        trap_mcause <= {1'b1, 26'b0, irq_code};
        trap_mtval  <= '0;
      end else if (take_mret) begin
        is_mret     <= 1'b1;
      end
      if (state_next == MSTAT) mstatus_wdata <= take_mret ? mst_mret : mst_trap;
      if (state_next == REDIR) redirect_pc   <= redirect_target;
    end
  end

endmodule

// File: tb/tb_mcu_trap_ctrl.sv
// Directed bench for mcu_trap_ctrl: expected CSR writes and redirects are queued
// at stimulus time and checked in order as the strobes appear.
module tb_mcu_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        exc_valid, mret_valid, irq_boundary;
  logic [4:0]  exc_cause;
  logic [31:0] exc_pc, exc_tval, irq_pc;
  logic        irq_sw, irq_timer, irq_ext, irq_wdog;
  logic [31:0] csr_mstatus, csr_mie, csr_mtvec, csr_mepc;
  logic        trap_we, mstatus_we, redirect_valid, busy;
  logic [31:0] trap_mepc, trap_mcause, trap_mtval, mstatus_wdata, redirect_pc, mip_value;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int          kind;   // 0 trap write, 1 mstatus write, 2 redirect
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
  } exp_t;
  exp_t sb[$];

  mcu_trap_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc), .exc_tval(exc_tval),
    .mret_valid(mret_valid), .irq_boundary(irq_boundary), .irq_pc(irq_pc),
    .irq_sw(irq_sw), .irq_timer(irq_timer), .irq_ext(irq_ext), .irq_wdog(irq_wdog),
    .csr_mstatus(csr_mstatus), .csr_mie(csr_mie), .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc),
    .trap_we(trap_we), .trap_mepc(trap_mepc), .trap_mcause(trap_mcause), .trap_mtval(trap_mtval),
    .mstatus_we(mstatus_we), .mstatus_wdata(mstatus_wdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .busy(busy), .mip_value(mip_value)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push(input int kind, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] c);
    exp_t e;
    e.kind = kind; e.a = a; e.b = b; e.c = c;
    sb.push_back(e);
  endtask

  task automatic expect_trap(input logic [31:0] mepc, input logic [31:0] mcause,
                             input logic [31:0] mtval, input logic [31:0] mst,
                             input logic [31:0] target);
    push(0, mepc, mcause, mtval);
    push(1, mst, 32'h0, 32'h0);
    push(2, target, 32'h0, 32'h0);
  endtask

  task automatic check_ev(input int kind, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c);
    exp_t e;
    if (sb.size() == 0) begin
      chk("unexpected_strobe_kind", 32'(kind), 32'hFFFF_FFFF);
    end else begin
      e = sb.pop_front();
      chk("strobe_kind", 32'(kind), 32'(e.kind));
      case (kind)
        0: begin
          chk("trap_mepc", a, e.a);
          chk("trap_mcause", b, e.b);
          chk("trap_mtval", c, e.c);
        end
        1:       chk("mstatus_wdata", a, e.a);
        default: chk("redirect_pc", a, e.a);
      endcase
    end
  endtask

  always @(negedge clk) begin
    if (trap_we)        check_ev(0, trap_mepc, trap_mcause, trap_mtval);
    if (mstatus_we)     check_ev(1, mstatus_wdata, 32'h0, 32'h0);
    if (redirect_valid) check_ev(2, redirect_pc, 32'h0, 32'h0);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Accept edge, then nbusy busy cycles, then idle with every queued event consumed.
  task automatic run(input int nbusy);
    cyc();
    exc_valid    = 1'b0;
    mret_valid   = 1'b0;
    irq_boundary = 1'b0;
    for (int i = 0; i < nbusy; i++) begin
      chk("busy_high", 32'(busy), 32'h1);
      cyc();
    end
    chk("busy_low", 32'(busy), 32'h0);
    chk("sb_drained", 32'(sb.size()), 32'h0);
  endtask

  task automatic clear_irqs();
    irq_sw = 1'b0; irq_timer = 1'b0; irq_ext = 1'b0; irq_wdog = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    exc_valid = 1'b0; mret_valid = 1'b0; irq_boundary = 1'b0;
    exc_cause = '0; exc_pc = '0; exc_tval = '0; irq_pc = '0;
    clear_irqs();
    csr_mstatus = '0; csr_mie = '0; csr_mtvec = '0; csr_mepc = '0;
    cyc();
    cyc();
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_trap_we", 32'(trap_we), 32'h0);
    chk("rst_mstatus_we", 32'(mstatus_we), 32'h0);
    chk("rst_redirect_valid", 32'(redirect_valid), 32'h0);
    chk("rst_trap_mepc", trap_mepc, 32'h0);
    chk("rst_mstatus_wdata", mstatus_wdata, 32'h0);
    chk("rst_redirect_pc", redirect_pc, 32'h0);
    chk("rst_mip", mip_value, 32'h0);
    rst_n = 1'b1;
    cyc();

    // Environment-call style exception, direct mtvec.
    csr_mtvec = 32'h2000; csr_mstatus = 32'h8;
    exc_valid = 1'b1; exc_cause = 5'd11; exc_pc = 32'h100; exc_tval = 32'h0;
    expect_trap(32'h100, 32'hB, 32'h0, 32'h1880, 32'h2000);
    run(3);

    // Timer interrupt, vectored mtvec.
    csr_mtvec = 32'h2001; csr_mstatus = 32'h8; csr_mie = 32'h80;
    irq_timer = 1'b1; irq_boundary = 1'b1; irq_pc = 32'h240;
    #1 chk("mip_timer", mip_value, 32'h80);
    expect_trap(32'h240, 32'h8000_0007, 32'h0, 32'h1880, 32'h201C);
    run(3);
    clear_irqs();

    // Masked by mstatus.MIE: nothing taken; exception still traps to base.
    csr_mstatus = 32'h0; csr_mie = 32'h800; irq_ext = 1'b1; irq_boundary = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("masked_busy", 32'(busy), 32'h0);
      chk("masked_mip", mip_value, 32'h800);
    end
    exc_valid = 1'b1; exc_cause = 5'd2; exc_pc = 32'h300; exc_tval = 32'hDEAD_BEEF;
    expect_trap(32'h300, 32'h2, 32'hDEAD_BEEF, 32'h1800, 32'h2000);
    run(3);
    clear_irqs();

    // Exception, MRET and ext interrupt together: exception wins, MRET dropped.
    csr_mstatus = 32'h8; csr_mie = 32'h800; csr_mepc = 32'h900;
    irq_ext = 1'b1; irq_boundary = 1'b1; irq_pc = 32'h500; mret_valid = 1'b1;
    exc_valid = 1'b1; exc_cause = 5'd2; exc_pc = 32'h400; exc_tval = 32'h44;
    expect_trap(32'h400, 32'h2, 32'h44, 32'h1880, 32'h2000);
    run(3);
    csr_mstatus = 32'h1880; irq_boundary = 1'b1;
    cyc();
    chk("ext_held_off_busy", 32'(busy), 32'h0);
    csr_mstatus = 32'h1888;
    expect_trap(32'h500, 32'h8000_000B, 32'h0, 32'h1880, 32'h202C);
    run(3);
    clear_irqs();

    // Priority: sw beats timer and watchdog; then watchdog alone.
    csr_mstatus = 32'h8; csr_mie = 32'h0001_0888;
    irq_sw = 1'b1; irq_timer = 1'b1; irq_wdog = 1'b1; irq_boundary = 1'b1; irq_pc = 32'h700;
    #1 chk("mip_multi", mip_value, 32'h0001_0088);
    expect_trap(32'h700, 32'h8000_0003, 32'h0, 32'h1880, 32'h200C);
    run(3);
    clear_irqs();
    csr_mie = 32'h0001_0000; irq_wdog = 1'b1; irq_boundary = 1'b1; irq_pc = 32'h704;
    expect_trap(32'h704, 32'h8000_0010, 32'h0, 32'h1880, 32'h2040);
    run(3);
    clear_irqs();

    // MRET restores MIE from MPIE and returns to the word-aligned mepc.
    csr_mstatus = 32'h1880; csr_mepc = 32'h105; mret_valid = 1'b1;
    push(1, 32'h1888, 32'h0, 32'h0);
    push(2, 32'h104, 32'h0, 32'h0);
    run(2);

    // Reset during the trap-write cycle aborts the sequence.
    exc_valid = 1'b1; exc_cause = 5'd5; exc_pc = 32'h600; exc_tval = 32'h66;
    push(0, 32'h600, 32'h5, 32'h66);
    cyc();
    exc_valid = 1'b0;
    chk("abort_trap_we", 32'(trap_we), 32'h1);
    rst_n = 1'b0;
    cyc();
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_trap_we_low", 32'(trap_we), 32'h0);
    chk("abort_mstatus_we", 32'(mstatus_we), 32'h0);
    chk("abort_redirect", 32'(redirect_valid), 32'h0);
    chk("abort_trap_mepc", trap_mepc, 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("post_abort_busy", 32'(busy), 32'h0);
    end
    chk("post_abort_sb", 32'(sb.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mcu_trap_ctrl.md
Name: mcu_trap_ctrl

Overview:
- Trap/interrupt sequencer for the control-processor MCU; the initiator side of the CSR file's trap-write interface.
- Arbitrates synchronous exceptions, MRET and level interrupts (sw/timer/ext/watchdog).
- Drives the trap_we/mepc/mcause/mtval write and a separate mstatus write, then issues a one-cycle PC redirect.
- Sits between core pipeline and CSR file; core stalls while busy.

Parameters:
- WDOG_CAUSE, 16, mcause code for watchdog interrupt (custom, >=16).
- RESET_MSTATUS_MPP, 2'b11, value written to mstatus.MPP on trap.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- exc_valid  in  1  synchronous exception this cycle
- exc_cause  in  5  exception code
- exc_pc  in  32  PC of faulting instruction
- exc_tval  in  32  trap value
- mret_valid  in  1  MRET retiring
- irq_boundary  in  1  core at instruction boundary; interrupt may be taken
- irq_pc  in  32  PC of next instruction (saved as mepc on interrupt)
- irq_sw, irq_timer, irq_ext, irq_wdog  in  1 each  level interrupt requests
- csr_mstatus, csr_mie, csr_mtvec, csr_mepc  in  32 each  current CSR values
- trap_we  out  1  CSR trap write strobe
- trap_mepc, trap_mcause, trap_mtval  out  32 each  trap write data
- mstatus_we  out  1  mstatus write strobe (integrator gives it priority on the CSR write port)
- mstatus_wdata  out  32  mstatus write data
- redirect_valid  out  1  PC redirect strobe
- redirect_pc  out  32  redirect target
- busy  out  1  sequencer active; core must stall
- mip_value  out  32  pending view: bit3 sw, bit7 timer, bit11 ext, bit WDOG_CAUSE wdog

Behaviour:
- Reset: state IDLE; all strobes 0; all data outputs 0; latched cause/pc/tval 0. Reset mid-sequence aborts immediately with no further strobes.
- mip_value is combinational from irq_* levels, independent of masks.
- Interrupt enable = csr_mstatus[3] & |(mip_value & csr_mie) & irq_boundary.
- Interrupt priority: ext(11) > sw(3) > timer(7) > wdog(WDOG_CAUSE).
- Event priority in IDLE: exception > mret > interrupt. Lower-priority simultaneous events are dropped; an interrupt level persists and is retaken later.
- States: IDLE, SAVE, MSTAT, REDIR. busy = (state != IDLE).
- Exception/interrupt accepted in cycle N (IDLE): latch fields, go to SAVE.
  - Exception latches: mepc = exc_pc; mcause = {27'b0, exc_cause}; tval = exc_tval.
  - Interrupt latches: mepc = irq_pc; mcause = {1'b1, 26'b0, code}; tval = 0.
  - Exceptions are taken regardless of mstatus.MIE.
- SAVE (N+1): trap_we = 1 with latched data; next state MSTAT.
- MSTAT after a trap (N+2): mstatus_we = 1.
  - mstatus_wdata = csr_mstatus with MPIE(7) = MIE(3), MIE = 0, MPP(12:11) = RESET_MSTATUS_MPP.
  - Next state REDIR.
- REDIR (N+3): redirect_valid = 1, then return to IDLE.
  - mtvec mode = csr_mtvec[1:0]; base = {csr_mtvec[31:2], 2'b00}.
  - Mode 1 and interrupt: redirect_pc = base + 4*code (32-bit wrap).
  - Otherwise (exceptions, and modes 0/2/3): redirect_pc = base.
- MRET accepted in cycle N: go directly to MSTAT (no trap_we).
  - MSTAT (N+1): mstatus_wdata = csr_mstatus with MIE = MPIE, MPIE = 1, MPP unchanged.
  - REDIR (N+2): redirect_pc = {csr_mepc[31:2], 2'b00}.
- Inputs presented while busy are ignored; the core guarantees none are presented.
- All strobes are single-cycle, registered outputs. Data outputs hold their last value when strobes are low.

Test Plan:
- mtvec = 0x2000, mstatus = 0x8, exc cause 11, pc 0x100, tval 0 at cycle N:
  - N+1: trap_we, mepc 0x100, mcause 0xB.
  - N+2: mstatus_wdata 0x1880.
  - N+3: redirect 0x2000.
  - busy high N+1..N+3.
- mtvec = 0x2001, mstatus = 0x8, mie = 0x80, irq_timer = 1, irq_boundary = 1, irq_pc = 0x240 -> mcause 0x80000007, mepc 0x240, tval 0, redirect 0x201C.
- mstatus.MIE = 0 with irq_ext = 1, mie = 0x800 -> no strobes, busy 0, mip_value = 0x800. Then exc cause 2 still traps to base.
- exc_valid, irq_ext and mret_valid in the same cycle -> exception taken (mcause 2); MRET dropped. irq_ext taken on the next boundary after mstatus.MIE is restored.
- MRET with mstatus = 0x1880, mepc = 0x105 -> N+1 mstatus_wdata 0x1888, N+2 redirect 0x104, no trap_we.
- rst_n low in SAVE cycle -> next cycle all strobes 0, busy 0; no mstatus_we or redirect follows.
